// File: rtl/mem_addr_pkg.sv
// Shared definitions for the memory-stage address generator: addressing-mode
// encodings, mode field width and the default stack-pointer reset value.
package mem_addr_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT   = 3'd0,
    MODE_POST_INC = 3'd1,
    MODE_PRE_DEC  = 3'd2,
    MODE_DISP     = 3'd3,
    MODE_PUSH     = 3'd4,
    MODE_POP      = 3'd5
  } addr_mode_e;

  localparam logic [15:0] DEFAULT_SP_RESET = 16'hFFFF;

  // Stack modes always address through SP regardless of the requested index.
  function automatic logic is_stack_mode(input logic [MODE_W-1:0] mode);
    return (mode == MODE_PUSH) || (mode == MODE_POP);
  endfunction

endpackage

// File: rtl/mem_addr_calc.sv
// Combinational address/next-pointer computation for one request.
// All arithmetic wraps modulo 2^ADDR_W.
module mem_addr_calc
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DISP_W = 6
) (
  input  logic [ADDR_W-1:0] ptr_val,
  input  logic [ADDR_W-1:0] sp_val,
  input  logic [MODE_W-1:0] mode,
  input  logic [DISP_W-1:0] disp,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_ptr,
  output logic              upd_en,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  always_comb begin
    addr     = ptr_val;
    next_ptr = ptr_val;
    upd_en   = 1'b0;
    illegal  = 1'b0;
    case (mode)
      MODE_DIRECT: begin
      end
      MODE_POST_INC: begin
        next_ptr = ptr_val + ONE;
        upd_en   = 1'b1;
      end
      MODE_PRE_DEC: begin
        addr     = ptr_val - ONE;
        next_ptr = ptr_val - ONE;
        upd_en   = 1'b1;
      end
      MODE_DISP: begin
        addr = ptr_val + ADDR_W'(disp);
      end
      MODE_PUSH: begin
        addr     = sp_val;
        next_ptr = sp_val - ONE;
        upd_en   = 1'b1;
      end
      MODE_POP: begin
        addr     = sp_val + ONE;
        next_ptr = sp_val + ONE;
        upd_en   = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_addr_gen.sv
// Memory-stage address generator: pointer file, addressing modes, one registered
// beat per request. Define MEM_ADDR_BOUNDS_CHECK_EN to enable the MEM_LIMIT check.
module mem_addr_gen
  import mem_addr_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                NUM_PTRS = 4,
  parameter int                SP_IDX   = NUM_PTRS - 1,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(DEFAULT_SP_RESET),
  parameter int                DISP_W   = 6
`ifdef MEM_ADDR_BOUNDS_CHECK_EN
  , parameter logic [ADDR_W-1:0] MEM_LIMIT = {ADDR_W{1'b1}}
`endif
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_PTRS)-1:0] req_ptr_sel,
  input  logic [MODE_W-1:0]           req_mode,
  input  logic [DISP_W-1:0]           req_disp,
  input  logic                        ptr_wr_en,
  input  logic [$clog2(NUM_PTRS)-1:0] ptr_wr_sel,
  input  logic [ADDR_W-1:0]           ptr_wr_data,
  input  logic [$clog2(NUM_PTRS)-1:0] ptr_rd_sel,
  output logic [ADDR_W-1:0]           ptr_rd_data,
  output logic                        addr_valid,
  input  logic                        addr_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mode_err,
  output logic                        addr_fault
);

  localparam int               SEL_W  = $clog2(NUM_PTRS);
  localparam logic [SEL_W-1:0] SP_SEL = SEL_W'(SP_IDX);

  logic [ADDR_W-1:0] ptrs [NUM_PTRS];
  logic [SEL_W-1:0]  eff_sel;
  logic [ADDR_W-1:0] sel_ptr;
  logic [ADDR_W-1:0] calc_addr;
  logic [ADDR_W-1:0] calc_next;
  logic              calc_upd;
  logic              calc_illegal;
  logic              accept;
  logic              bounds_fault;
  logic              issue;

  assign eff_sel     = is_stack_mode(req_mode) ? SP_SEL : req_ptr_sel;
  assign sel_ptr     = ptrs[eff_sel];
  assign ptr_rd_data = ptrs[ptr_rd_sel];

  mem_addr_calc #(
    .ADDR_W (ADDR_W),
    .DISP_W (DISP_W)
  ) u_calc (
    .ptr_val  (sel_ptr),
    .sp_val   (ptrs[SP_IDX]),
    .mode     (req_mode),
    .disp     (req_disp),
    .addr     (calc_addr),
    .next_ptr (calc_next),
    .upd_en   (calc_upd),
    .illegal  (calc_illegal)
  );

`ifdef MEM_ADDR_BOUNDS_CHECK_EN
  assign bounds_fault = (calc_addr > MEM_LIMIT);
`else
  assign bounds_fault = 1'b0;
`endif

  // Single output stage: a new request may enter whenever the held beat leaves.
  assign req_ready = !addr_valid || addr_ready;
  assign accept    = req_valid && req_ready;
  assign issue     = accept && !calc_illegal && !bounds_fault;

  // An external load outranks the mode update on the same pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PTRS; i++) begin
        ptrs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NUM_PTRS; i++) begin
        if (ptr_wr_en && (ptr_wr_sel == SEL_W'(i))) begin
          ptrs[i] <= ptr_wr_data;
        end else if (issue && calc_upd && (eff_sel == SEL_W'(i))) begin
          ptrs[i] <= calc_next;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_valid <= 1'b0;
      mem_addr   <= '0;
      mode_err   <= 1'b0;
    end else begin
      mode_err <= accept && calc_illegal;
      if (issue) begin
        addr_valid <= 1'b1;
        mem_addr   <= calc_addr;
      end else if (addr_ready) begin
        addr_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_ADDR_BOUNDS_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_fault <= 1'b0;
    end else begin
      addr_fault <= accept && !calc_illegal && bounds_fault;
    end
  end
`else
  assign addr_fault = 1'b0;
`endif

endmodule
